adc_frame_streamer: RTL and testbench
=====================================

// Module: adc_frame_streamer
// PURPOSE
//  Captures one frame of FRAME_LEN signed ADC samples into an internal buffer, then replays it as an
//  AXI-Stream master (tvalid/tready/tlast). This is the source end of the frame stream consumed by the
//  peak-search blocks (find_max family). One beat per accepted handshake; tlast marks the final sample.
// PARAMETERS
//  DATA_WIDTH  8   sample width, two's complement
//  ADDR_WIDTH  6   buffer address width; buffer depth = 2**ADDR_WIDTH
//  FRAME_LEN   64  samples per frame; legal range 2..2**ADDR_WIDTH
// PORTS
//  clk_in         in   1           single clock; all logic on rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  start          in   1           1-cycle pulse: arm capture of one frame (ignored unless IDLE)
//  adc_valid      in   1           sample strobe
//  adc_data       in   DATA_WIDTH  signed sample, sampled when adc_valid=1
//  m_axis_tready  in   1           downstream ready
//  m_axis_tvalid  out  1           beat valid
//  m_axis_tdata   out  DATA_WIDTH  signed sample
//  m_axis_tlast   out  1           high with beat FRAME_LEN-1 only
//  m_axis_taddr   out  ADDR_WIDTH  beat index 0..FRAME_LEN-1, aligned with tdata
//  busy           out  1           high in CAPTURE, STREAM, GAP
//  frame_done     out  1           1-cycle pulse the cycle after the tlast handshake
//  drop_flag      out  1           sticky: adc_valid seen in STREAM/GAP; cleared by accepted start
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, all outputs 0, counters 0; buffer contents undefined.
//  FSM: IDLE -start-> CAPTURE -(FRAME_LEN-th sample written)-> STREAM -(tlast handshake)-> GAP -> IDLE.
//  CAPTURE: each adc_valid writes buf[wr_addr], wr_addr++; gaps in adc_valid simply wait.
//   Write of sample FRAME_LEN-1 moves to STREAM next cycle; wr_addr returns to 0.
//  STREAM: output register stage; load when (!m_axis_tvalid || m_axis_tready).
//   First beat valid 1 cycle after entering STREAM (buffer read is combinational).
//   While tvalid=1 and tready=0: tdata/taddr/tlast held stable, tvalid stays 1 (AXI rule).
//   Back-to-back beats at full rate when tready=1 continuously: FRAME_LEN beats in FRAME_LEN cycles.
//   tvalid never deasserts mid-frame once asserted (no bubbles; buffer is full).
//  GAP: exactly one cycle with tvalid=0 after the tlast beat (downstream clear cycle); frame_done=1 here.
//  Boundaries: start while busy ignored; start coincident with adc_valid in IDLE: that sample is NOT
//   captured (capture begins next cycle). adc_valid in STREAM/GAP sets drop_flag, data discarded.
//   rst_n low mid-frame: tvalid drops immediately (async), partial frame discarded, no tlast emitted.
//   FRAME_LEN=2**ADDR_WIDTH: address counters wrap to 0 at end, no overflow beyond buffer.
// CONFIGURATION
//  AUTO_RESTART_EN defined: GAP -> CAPTURE directly (continuous framing, start ignored after first);
//   drop_flag still set by samples arriving in STREAM/GAP. busy stays 1 after first start.
//  AUTO_RESTART_EN undefined: GAP -> IDLE; every frame requires its own start pulse.
// TESTING (bench: DATA_WIDTH=8, ADDR_WIDTH=3, FRAME_LEN=8)
//  1 reset, start, adc_data=-4..3 with adc_valid=1, tready=1 -> 8 beats tdata -4..3, taddr 0..7,
//    tlast only on 3, frame_done 1 cycle later, busy drops after GAP.
//  2 same frame, tready toggling 1,0,0,1,... -> no beat lost/duplicated, tdata stable while tready=0.
//  3 adc_valid every 3rd cycle during capture -> stream starts only after 8th sample; order preserved.
//  4 adc_valid=1 during STREAM -> drop_flag=1, output frame unchanged; next start clears drop_flag.
//  5 rst_n pulsed low at beat 4 -> tvalid=0 same cycle, state IDLE, no tlast; new start works normally.
//  6 AUTO_RESTART_EN, continuous adc_valid -> frames repeat, exactly 1 tvalid=0 cycle between tlasts.

Source files
------------

// File: rtl/adc_frame_streamer_if.sv
// Frame output bus: AXI-Stream handshake plus a beat-index sideband (taddr) aligned with tdata.
// The streamer drives the master modport; a find_max style consumer takes the slave modport.
interface adc_frame_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                         tvalid;
  logic                         tready;
  logic signed [DATA_WIDTH-1:0] tdata;
  logic                         tlast;
  logic [ADDR_WIDTH-1:0]        taddr;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output taddr,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  taddr,
    output tready
  );
endinterface

// File: rtl/adc_frame_streamer.sv
// Captures FRAME_LEN signed ADC samples into a buffer, then replays them as an AXI-Stream frame.
// Optional feature macro AUTO_RESTART_EN: GAP returns straight to CAPTURE for continuous framing.
module adc_frame_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FRAME_LEN  = 64
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         adc_valid,
  input  logic signed [DATA_WIDTH-1:0] adc_data,
  adc_frame_streamer_if.master         m_axis,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         drop_flag
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_STREAM,
    S_GAP
  } state_t;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic signed [DATA_WIDTH-1:0] frame_buf [DEPTH];

  logic capture_wr;
  logic stray_sample;
  logic tx_load;

  assign capture_wr   = (state == S_CAPTURE) && adc_valid;
  assign stray_sample = adc_valid && ((state == S_STREAM) || (state == S_GAP));
  // The output stage takes a new beat when empty or when the current beat is being accepted.
  assign tx_load      = !m_axis.tvalid || m_axis.tready;

  // NOTE: the sample buffer is deliberately left out of reset; every location is rewritten by
  // capture before it is streamed, and a resettable array would not map onto RAM.
  always_ff @(posedge clk_in) begin
    if (capture_wr) begin
      frame_buf[wr_addr] <= adc_data;
    end
  end

  // NOTE: all state and output registers use non-blocking assignment so every read in this block
  // sees the pre-edge value, which is what makes the handshake and address logic cycle-exact.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_addr       <= '0;
      rd_addr       <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tlast  <= 1'b0;
      m_axis.taddr  <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      drop_flag     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (stray_sample) begin
        drop_flag <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CAPTURE;
            busy      <= 1'b1;
            drop_flag <= 1'b0;
            wr_addr   <= '0;
          end
        end

        S_CAPTURE: begin
          if (adc_valid) begin
            if (wr_addr == LAST_ADDR) begin
              wr_addr <= '0;
              rd_addr <= '0;
              state   <= S_STREAM;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end

        S_STREAM: begin
          if (tx_load) begin
            if (m_axis.tvalid && m_axis.tlast) begin
              // Final beat accepted: leave one empty cycle for the consumer.
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              frame_done    <= 1'b1;
              state         <= S_GAP;
            end else begin
              m_axis.tvalid <= 1'b1;
              m_axis.tdata  <= frame_buf[rd_addr];
              m_axis.taddr  <= rd_addr;
              m_axis.tlast  <= (rd_addr == LAST_ADDR);
              rd_addr       <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            end
          end
        end

        S_GAP: begin
`ifdef AUTO_RESTART_EN
          state <= S_CAPTURE;
`else
          state <= S_IDLE;
          busy  <= 1'b0;
`endif
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_streamer.sv
// Self-checking bench for adc_frame_streamer: a table of frame scenarios plus a mid-frame reset,
// all scored cycle by cycle against a frame/beat-index reference model.
module tb_adc_frame_streamer;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int FL = 8;
`ifdef AUTO_RESTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic                 clk_in    = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 start     = 1'b0;
  logic                 adc_valid = 1'b0;
  logic signed [DW-1:0] adc_data  = '0;
  logic                 busy;
  logic                 frame_done;
  logic                 drop_flag;

  adc_frame_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axis ();

  adc_frame_streamer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FRAME_LEN (FL)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .start     (start),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .m_axis    (axis),
    .busy      (busy),
    .frame_done(frame_done),
    .drop_flag (drop_flag)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: where the frame is in its life, which samples were kept, which beat is on offer.
  typedef enum {P_IDLE, P_CAP, P_STR, P_GAP} phase_e;
  phase_e               m_phase;
  logic signed [DW-1:0] m_frame [FL];
  int                   m_wr;
  bit                   m_valid;
  int                   m_idx;
  bit                   m_done;
  bit                   m_drop;
  int                   m_frames = 0;

  task automatic model_reset();
    m_phase = P_IDLE;
    m_wr    = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_done  = 1'b0;
    m_drop  = 1'b0;
  endtask

  task automatic model_step();
    bit nd = 1'b0;
    case (m_phase)
      P_IDLE: if (start) begin
        m_phase = P_CAP;
        m_wr    = 0;
        m_drop  = 1'b0;
      end
      P_CAP: if (adc_valid) begin
        m_frame[m_wr] = adc_data;
        m_wr++;
        if (m_wr == FL) m_phase = P_STR;
      end
      P_STR: begin
        if (adc_valid) m_drop = 1'b1;
        if (!m_valid) begin
          m_valid = 1'b1;
          m_idx   = 0;
        end else if (axis.tready) begin
          if (m_idx == FL - 1) begin
            m_valid = 1'b0;
            m_phase = P_GAP;
            nd      = 1'b1;
            m_frames++;
          end else begin
            m_idx++;
          end
        end
      end
      P_GAP: begin
        if (adc_valid) m_drop = 1'b1;
        m_wr    = 0;
        m_phase = AUTO ? P_CAP : P_IDLE;
      end
    endcase
    m_done = nd;
  endtask

  task automatic compare_outputs();
    check("tvalid", axis.tvalid, m_valid);
    if (m_valid) begin
      check("tdata", axis.tdata, m_frame[m_idx]);
      check("taddr", axis.taddr, m_idx);
      check("tlast", axis.tlast, (m_idx == FL - 1));
    end else begin
      check("tlast_idle", axis.tlast, 1'b0);
    end
    check("busy", busy, (m_phase != P_IDLE));
    check("frame_done", frame_done, m_done);
    check("drop_flag", drop_flag, m_drop);
  endtask

  // One clock: inputs already driven; sample the DUT 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk_in);
    model_step();
    #1;
    compare_outputs();
  endtask

  typedef struct {
    int adc_period;   // adc_valid every Nth cycle while capturing
    int ready_mode;   // 0 always ready, 1 pattern 1,0,0, 2 random
    int data_mode;    // 0 ramp -4.., 1 random
    bit coincident;   // adc_valid together with start
    bit inject_drop;  // adc_valid during STREAM/GAP
    bit start_mid;    // start pulse while streaming
    int exp_beats;
    int exp_lasts;
    int exp_span;     // cycles from first to last handshake, 0 = not checked
    bit exp_drop;
  } vec_t;

  task automatic run_frame(input vec_t v, output int beats, output int lasts, output int span,
                           output logic drop_end);
    int                   t = 0;
    int                   k = 0;
    int                   first_t = -1;
    int                   last_t = -1;
    int                   f0;
    bit                   mid_done = 1'b0;
    logic                 stall_prev = 1'b0;
    logic signed [DW-1:0] data_prev = '0;
    logic [AW-1:0]        addr_prev = '0;
    beats = 0;
    lasts = 0;
    f0 = m_frames;
    start       = 1'b1;
    adc_valid   = v.coincident;
    adc_data    = 8'sh55;
    axis.tready = 1'b0;
    cycle();
    while ((m_frames == f0 || m_phase == P_GAP) && t < 300) begin
      if (stall_prev) begin
        check("stall_tvalid", axis.tvalid, 1'b1);
        check("stall_tdata", axis.tdata, data_prev);
        check("stall_taddr", axis.taddr, addr_prev);
      end
      start = 1'b0;
      if (m_phase == P_CAP) begin
        adc_valid = ((t % v.adc_period) == 0);
        adc_data  = (v.data_mode == 0) ? DW'(k - 4) : DW'($urandom);
        if (adc_valid) k++;
      end else begin
        adc_valid = v.inject_drop && (m_phase == P_STR || m_phase == P_GAP);
        adc_data  = DW'($urandom);
        if (v.start_mid && m_phase == P_STR && !mid_done) begin
          start    = 1'b1;
          mid_done = 1'b1;
        end
      end
      case (v.ready_mode)
        0:       axis.tready = 1'b1;
        1:       axis.tready = ((t % 3) == 0);
        default: axis.tready = 1'($urandom_range(0, 1));
      endcase
      if (axis.tvalid && axis.tready) begin
        beats++;
        if (first_t < 0) first_t = t;
        if (axis.tlast) begin
          lasts++;
          last_t = t;
        end
      end
      stall_prev = axis.tvalid && !axis.tready;
      data_prev  = axis.tdata;
      addr_prev  = axis.taddr;
      cycle();
      t++;
    end
    start     = 1'b0;
    adc_valid = 1'b0;
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got %0d cycles expected under 300", t);
    end
    span     = (first_t < 0 || last_t < 0) ? 0 : last_t - first_t + 1;
    drop_end = drop_flag;
  endtask

  // Reset asserted while beat 4 is on the bus: outputs must drop at once, no tlast ever appears.
  task automatic reset_mid_frame();
    int t = 0;
    int lasts = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < FL; i++) begin
      adc_valid = 1'b1;
      adc_data  = DW'(i * 3 - 5);
      cycle();
    end
    adc_valid   = 1'b0;
    axis.tready = 1'b1;
    while (!(m_valid && m_idx == 4) && t < 40) begin
      if (axis.tvalid && axis.tready && axis.tlast) lasts++;
      cycle();
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL rst_wait_beat4: got %0d cycles expected under 40", t);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_tvalid", axis.tvalid, 1'b0);
    check("rst_async_tlast", axis.tlast, 1'b0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_no_tlast", lasts, 0);
    model_reset();
    axis.tready = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    cycle();
  endtask

  vec_t tbl [5];

  initial begin
    int   beats;
    int   lasts;
    int   span;
    logic drop_end;

    tbl[0] = '{1, 0, 0, 1'b1, 1'b0, 1'b0, FL, 1, FL, 1'b0};
    tbl[1] = '{1, 1, 0, 1'b0, 1'b0, 1'b0, FL, 1, 0,  1'b0};
    tbl[2] = '{3, 0, 1, 1'b0, 1'b0, 1'b0, FL, 1, FL, 1'b0};
    tbl[3] = '{1, 2, 1, 1'b0, 1'b1, 1'b1, FL, 1, 0,  1'b1};
    tbl[4] = '{2, 2, 1, 1'b0, 1'b0, 1'b0, FL, 1, 0,  AUTO};

    model_reset();
    axis.tready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_tvalid", axis.tvalid, 1'b0);
    check("reset_tdata", axis.tdata, 0);
    check("reset_tlast", axis.tlast, 1'b0);
    check("reset_taddr", axis.taddr, 0);
    check("reset_busy", busy, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_drop_flag", drop_flag, 1'b0);
    @(negedge clk_in);
    rst_n = 1'b1;
    cycle();

    reset_mid_frame();

    for (int r = 0; r < 5; r++) begin
      run_frame(tbl[r], beats, lasts, span, drop_end);
      check($sformatf("row%0d_beats", r), beats, tbl[r].exp_beats);
      check($sformatf("row%0d_lasts", r), lasts, tbl[r].exp_lasts);
      if (tbl[r].exp_span > 0) check($sformatf("row%0d_span", r), span, tbl[r].exp_span);
      check($sformatf("row%0d_drop", r), drop_end, tbl[r].exp_drop);
    end

    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
